dec_entry_bin: RTL and testbench
================================

// Module: dec_entry_bin
// PURPOSE
//  Operator input path of the board: reads raw push-buttons and lets the user dial
//  a NDIG-digit decimal number. Each button is synchronised, debounced and edge-detected.
//  On ENTER, converts the BCD digits to binary serially (Horner: acc*10+d).
//  Delivers the value to the CPU side over a valid/ready handshake.
//  The live digits go back out to the seg7 display decoders.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable clocks before a debounced level changes
//  NDIG             4   number of decimal digits entered
//  OUT_W            16  width of binary result; 10**NDIG-1 must fit (9999 < 2**16)
// PORTS
//  clk        in   1          system clock, single clock domain
//  rst        in   1          asynchronous, active-low reset
//  btn_inc    in   1          raw button, active-high: increment selected digit
//  btn_next   in   1          raw button: select next digit
//  btn_enter  in   1          raw button: start conversion
//  btn_clr    in   1          raw button: clear all digits
//  digits     out  4*NDIG     BCD digits; [3:0] = digit 0 (least significant)
//  sel        out  clog2(NDIG) index of digit being edited
//  out_value  out  OUT_W      converted binary value, stable while out_valid=1
//  out_valid  out  1          result available
//  out_ready  in   1          consumer accepts result on clk edge when out_valid=1
//  busy       out  1          high in CONV and VALID states
// BEHAVIOUR
//  Reset (rst=0, async): digits=0, sel=0, out_value=0, out_valid=0, busy=0, FSM=IDLE.
//   Sync flops, debounce counters and debounced levels are also 0.
//   A reset mid-conversion or mid-handshake aborts it immediately. No result is emitted.
//  Buttons: 2-flop sync, then a per-button counter.
//   The debounced level follows the synced level only after DEBOUNCE_CYCLES equal samples.
//   A 0->1 change of the debounced level gives a 1-cycle press pulse.
//   A held button gives exactly one pulse.
//  IDLE (edit): at most one action per cycle. Priority: clr > enter > next > inc.
//   Lower-priority pulses in the same cycle are dropped.
//   inc:  digit[sel] = (digit==9) ? 0 : digit+1
//   next: sel = (sel==NDIG-1) ? 0 : sel+1
//   clr:  all digits=0, sel=0
//   enter: acc=0, idx=NDIG-1, go to CONV, busy=1
//  CONV: one step per clock: acc <= acc*10 + digit[idx], idx--.
//   After NDIG steps, out_value <= acc and out_valid <= 1; go to VALID.
//   With the enter pulse at cycle T, out_valid is first high in cycle T+NDIG+1.
//   Arithmetic is unsigned, OUT_W bits wide; no overflow occurs given the parameter rule.
//  VALID: out_valid and out_value are held until a clock edge with out_ready=1.
//   Then out_valid=0, busy=0, return to IDLE.
//   out_value keeps its last result; out_ready while not valid is ignored.
//  CONV/VALID: all press pulses are discarded (not queued).
//   digits and sel do not change during conversion.
// TESTING
//  1 Reset: pulse rst low at random points (incl. mid-CONV) -> all outputs 0 at once,
//    no out_valid ever follows.
//  2 Entry 1,2,3,4 (digit3..0) via inc/next presses, then enter at T
//    -> out_valid at T+5, out_value=16'h04D2.
//    Held 10 cycles with out_ready=0; falls the cycle after out_ready=1.
//  3 Wrap: 10 inc on digit0 -> returns to 0; 4 next -> sel returns to 0.
//  4 Debounce: btn_inc toggled every 3 clks for 12 clks, then high 40 clks -> exactly one increment.
//    A 10-cycle high glitch -> no increment.
//  5 Max/priority: 9,9,9,9 + enter -> 16'h270F.
//    inc/clr presses while busy -> digits unchanged.
//    Simultaneous clr+inc pulses in IDLE -> clear only.
//  6 Back-to-back: out_ready tied 1, two enters with different digits -> two results in order,
//    each valid exactly one cycle.

Source files
------------

// File: rtl/dec_entry_bin.sv
// Push-button decimal entry: per-button sync + debounce + press detect, BCD digit
// editing, serial BCD-to-binary conversion and a valid/ready result handshake.
module dec_entry_bin #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned NDIG            = 4,
  parameter int unsigned OUT_W           = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_inc,
  input  logic                    btn_next,
  input  logic                    btn_enter,
  input  logic                    btn_clr,
  output logic [4*NDIG-1:0]       digits,
  output logic [$clog2(NDIG)-1:0] sel,
  output logic [OUT_W-1:0]        out_value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int unsigned SEL_W = $clog2(NDIG);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NBTN  = 4;
  localparam int unsigned B_INC = 0;
  localparam int unsigned B_NXT = 1;
  localparam int unsigned B_ENT = 2;
  localparam int unsigned B_CLR = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  sync1_q, sync1_d;
  logic [NBTN-1:0]  sync2_q, sync2_d;
  logic [NBTN-1:0]  deb_q, deb_d;
  logic [NBTN-1:0]  deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];
  logic [NBTN-1:0]  press;

  state_e            state_q, state_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  out_value_q, out_value_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [3:0]        sel_digit;
  logic [3:0]        idx_digit;
  logic [OUT_W-1:0]  step_val;

  assign btn_raw = {btn_clr, btn_enter, btn_next, btn_inc};

  // Synchroniser and debounce: level flips only after DEBOUNCE_CYCLES differing samples
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!press[B_CLR] && press[B_ENT]) state_d = ST_CONV;
      end
      ST_CONV: begin
        if (idx_q == '0) state_d = ST_VALID;
      end
      ST_VALID: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel_digit = digits_q[4*int'(sel_q) +: 4];
  assign idx_digit = digits_q[4*int'(idx_q) +: 4];
  // Horner step: acc*10 + digit, with *10 as (acc<<3)+(acc<<1)
  assign step_val  = (acc_q << 3) + (acc_q << 1) + {{(OUT_W-4){1'b0}}, idx_digit};

  // Datapath / output logic
  always_comb begin
    digits_d    = digits_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (press[B_CLR]) begin
          digits_d = '0;
          sel_d    = '0;
        end else if (press[B_ENT]) begin
          acc_d = '0;
          idx_d = SEL_W'(NDIG - 1);
        end else if (press[B_NXT]) begin
          sel_d = (sel_q == SEL_W'(NDIG - 1)) ? '0 : sel_q + SEL_W'(1);
        end else if (press[B_INC]) begin
          digits_d[4*int'(sel_q) +: 4] = (sel_digit == 4'd9) ? 4'd0 : sel_digit + 4'd1;
        end
      end
      ST_CONV: begin
        acc_d = step_val;
        idx_d = idx_q - SEL_W'(1);
        if (idx_q == '0) begin
          out_value_d = step_val;
          out_valid_d = 1'b1;
        end
      end
      ST_VALID: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: out_valid_d = 1'b0;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q    <= '0;
      sel_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      digits_q    <= digits_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign digits    = digits_q;
  assign sel       = sel_q;
  assign out_value = out_value_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dec_entry_bin.sv
// Directed bench for dec_entry_bin: entry, wrap, debounce, priority, handshake, reset.
module tb_dec_entry_bin;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_inc = 1'b0, btn_next = 1'b0, btn_enter = 1'b0, btn_clr = 1'b0;
  logic [15:0] digits;
  logic [1:0]  sel;
  logic [15:0] out_value;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  dec_entry_bin #(.DEBOUNCE_CYCLES(16), .NDIG(4), .OUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .btn_inc(btn_inc), .btn_next(btn_next), .btn_enter(btn_enter), .btn_clr(btn_clr),
    .digits(digits), .sel(sel), .out_value(out_value), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask = {clr, enter, next, inc}: hold long enough to debounce, then release
  task automatic press(input logic [3:0] m);
    {btn_clr, btn_enter, btn_next, btn_inc} = m;
    cycles(30);
    {btn_clr, btn_enter, btn_next, btn_inc} = 4'b0000;
    cycles(30);
  endtask

  task automatic incs(input int n);
    repeat (n) press(4'b0001);
  endtask

  // Holds enter; lat = cycles from busy rising to out_valid rising. Enter stays high.
  task automatic start_enter(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    btn_enter = 1'b1;
    for (int i = 0; i < 60 && !busy; i++) @(negedge clk);
    if (busy) begin
      for (int i = 0; i < 20 && !out_valid; i++) begin
        @(negedge clk);
        lat++;
      end
      ok = out_valid;
    end
  endtask

  task automatic test_reset;
    int  lat;
    bit  ok;
    bit  bad;
    cycles(3);
    n_tests++;
    if ({digits, sel, out_value, out_valid, busy} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_init got=%h/%h/%h/%b/%b exp=all zero", digits, sel, out_value, out_valid, busy);
    end
    rst = 1'b1;
    cycles(3);
    incs(3);
    n_tests++;
    if (digits !== 16'h0003) begin
      n_fail++; $display("FAIL reset_setup digits got=%h exp=0003", digits);
    end
    // abort mid-conversion
    btn_enter = 1'b1;
    for (int i = 0; i < 60 && !busy; i++) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy_timeout got=%b exp=1", busy);
    end
    cycles(1);
    rst = 1'b0;
    btn_enter = 1'b0;
    #1;
    n_tests++;
    if ({digits, sel, out_value, out_valid, busy} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_midconv got=%h/%h/%h/%b/%b exp=all zero", digits, sel, out_value, out_valid, busy);
    end
    cycles(2);
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || busy) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_result got=%b exp=0", bad);
    end
    // abort mid-handshake
    incs(2);
    start_enter(lat, ok);
    n_tests++;
    if (ok !== 1'b1 || out_value !== 16'h0002) begin
      n_fail++; $display("FAIL reset_pre_valid got ok=%b value=%h exp ok=1 value=0002", ok, out_value);
    end
    rst = 1'b0;
    btn_enter = 1'b0;
    #1;
    n_tests++;
    if ({digits, sel, out_value, out_valid, busy} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_midvalid got=%h/%h/%h/%b/%b exp=all zero", digits, sel, out_value, out_valid, busy);
    end
    cycles(2);
    rst = 1'b1;
    cycles(30);
  endtask

  task automatic test_entry;
    int  lat;
    bit  ok;
    bit  held;
    press(4'b1000);
    incs(4); press(4'b0010);
    incs(3); press(4'b0010);
    incs(2); press(4'b0010);
    incs(1);
    n_tests++;
    if (digits !== 16'h1234 || sel !== 2'd3) begin
      n_fail++; $display("FAIL entry_digits got=%h sel=%0d exp=1234 sel=3", digits, sel);
    end
    start_enter(lat, ok);
    n_tests++;
    if (ok !== 1'b1 || lat != 4) begin
      n_fail++; $display("FAIL entry_latency got ok=%b lat=%0d exp ok=1 lat=4", ok, lat);
    end
    n_tests++;
    if (out_value !== 16'h04D2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL entry_value got=%h busy=%b exp=04d2 busy=1", out_value, busy);
    end
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_value !== 16'h04D2) held = 1'b0;
    end
    n_tests++;
    if (held !== 1'b1) begin
      n_fail++; $display("FAIL entry_hold got=%b exp=1", held);
    end
    out_ready = 1'b1;
    cycles(1);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_value !== 16'h04D2) begin
      n_fail++; $display("FAIL entry_accept got valid=%b busy=%b value=%h exp 0/0/04d2", out_valid, busy, out_value);
    end
    out_ready = 1'b0;
    btn_enter = 1'b0;
    cycles(30);
    n_tests++;
    if (digits !== 16'h1234 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL entry_after got digits=%h valid=%b exp 1234/0", digits, out_valid);
    end
  endtask

  task automatic test_wrap;
    press(4'b1000);
    n_tests++;
    if (digits !== 16'h0000 || sel !== 2'd0) begin
      n_fail++; $display("FAIL wrap_clear got=%h sel=%0d exp=0000 sel=0", digits, sel);
    end
    incs(9);
    n_tests++;
    if (digits !== 16'h0009) begin
      n_fail++; $display("FAIL wrap_nine got=%h exp=0009", digits);
    end
    incs(1);
    n_tests++;
    if (digits !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_digit got=%h exp=0000", digits);
    end
    repeat (3) press(4'b0010);
    n_tests++;
    if (sel !== 2'd3) begin
      n_fail++; $display("FAIL wrap_sel3 got=%0d exp=3", sel);
    end
    press(4'b0010);
    n_tests++;
    if (sel !== 2'd0) begin
      n_fail++; $display("FAIL wrap_sel got=%0d exp=0", sel);
    end
  endtask

  task automatic test_debounce;
    press(4'b1000);
    for (int k = 0; k < 4; k++) begin
      btn_inc = (k % 2 == 0);
      cycles(3);
    end
    btn_inc = 1'b1;
    cycles(40);
    btn_inc = 1'b0;
    cycles(40);
    n_tests++;
    if (digits !== 16'h0001) begin
      n_fail++; $display("FAIL debounce_bouncy got=%h exp=0001", digits);
    end
    btn_inc = 1'b1;
    cycles(10);
    btn_inc = 1'b0;
    cycles(40);
    n_tests++;
    if (digits !== 16'h0001) begin
      n_fail++; $display("FAIL debounce_glitch got=%h exp=0001", digits);
    end
  endtask

  task automatic test_max_priority;
    int lat;
    bit ok;
    press(4'b1000);
    for (int d = 0; d < 4; d++) begin
      incs(9);
      if (d < 3) press(4'b0010);
    end
    n_tests++;
    if (digits !== 16'h9999) begin
      n_fail++; $display("FAIL max_digits got=%h exp=9999", digits);
    end
    start_enter(lat, ok);
    n_tests++;
    if (ok !== 1'b1 || lat != 4 || out_value !== 16'h270F) begin
      n_fail++; $display("FAIL max_value got ok=%b lat=%0d value=%h exp 1/4/270f", ok, lat, out_value);
    end
    btn_enter = 1'b0;
    press(4'b0001);
    press(4'b1000);
    n_tests++;
    if (digits !== 16'h9999 || sel !== 2'd3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL busy_ignore got=%h sel=%0d valid=%b exp 9999/3/1", digits, sel, out_valid);
    end
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    cycles(30);
    press(4'b0010);
    press(4'b0001);
    n_tests++;
    if (digits !== 16'h9990 || sel !== 2'd0) begin
      n_fail++; $display("FAIL prio_setup got=%h sel=%0d exp=9990 sel=0", digits, sel);
    end
    press(4'b1001);
    n_tests++;
    if (digits !== 16'h0000 || sel !== 2'd0) begin
      n_fail++; $display("FAIL prio_clr_inc got=%h sel=%0d exp=0000 sel=0", digits, sel);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit ok;
    press(4'b1000);
    incs(5);
    out_ready = 1'b1;
    start_enter(lat, ok);
    n_tests++;
    if (ok !== 1'b1 || lat != 4 || out_value !== 16'h0005) begin
      n_fail++; $display("FAIL b2b_first got ok=%b lat=%0d value=%h exp 1/4/0005", ok, lat, out_value);
    end
    cycles(1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first_onecycle got=%b exp=0", out_valid);
    end
    btn_enter = 1'b0;
    cycles(30);
    press(4'b0010);
    incs(1);
    start_enter(lat, ok);
    n_tests++;
    if (ok !== 1'b1 || lat != 4 || out_value !== 16'h000F) begin
      n_fail++; $display("FAIL b2b_second got ok=%b lat=%0d value=%h exp 1/4/000f", ok, lat, out_value);
    end
    cycles(1);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_onecycle got valid=%b busy=%b exp 0/0", out_valid, busy);
    end
    btn_enter = 1'b0;
    out_ready = 1'b0;
    cycles(30);
  endtask

  initial begin
    test_reset;
    test_entry;
    test_wrap;
    test_debounce;
    test_max_priority;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
